// File: rtl/krnl_partialknn_local_sp_stager.sv
// Local scratchpad stager: FILL writes an input burst into a single-port URAM, and DRAIN
// streams it back out in order. A small credit-managed skid FIFO absorbs the read latency.
module krnl_partialknn_local_sp_stager #(
  parameter int DATA_WIDTH  = 256,
  parameter int ADDR_RANGE  = 2048,
  parameter int ADDR_WIDTH  = 11,
  parameter int MEM_LATENCY = 1,
  parameter int SKID_DEPTH  = MEM_LATENCY + 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   num_words,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] mem_address0,
  output logic                  mem_ce0,
  output logic                  mem_we0,
  output logic [DATA_WIDTH-1:0] mem_d0,
  input  logic [DATA_WIDTH-1:0] mem_q0
);

  localparam int LW = ADDR_WIDTH + 1;
  localparam int PW = $clog2(SKID_DEPTH);
  localparam int CW = $clog2(SKID_DEPTH + 1);
  localparam int IW = $clog2(MEM_LATENCY + 1);
  localparam int SW = $clog2(SKID_DEPTH + MEM_LATENCY + 1);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_DRAIN, S_DONE} state_t;

  state_t                                 state_q, state_d;
  logic [LW-1:0]                          len_q, len_d;
  logic [LW-1:0]                          wr_cnt_q, wr_cnt_d;
  logic                                   wr_pend_q, wr_pend_d;
  logic [ADDR_WIDTH-1:0]                  wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0]                  wr_data_q, wr_data_d;
  logic [LW-1:0]                          rd_addr_q, rd_addr_d;
  logic [LW-1:0]                          out_cnt_q, out_cnt_d;
  logic [MEM_LATENCY-1:0]                 vld_pipe_q, vld_pipe_d;
  logic [SKID_DEPTH-1:0][DATA_WIDTH-1:0]  fifo_mem_q, fifo_mem_d;
  logic [PW-1:0]                          fifo_wp_q, fifo_wp_d;
  logic [PW-1:0]                          fifo_rp_q, fifo_rp_d;
  logic [CW-1:0]                          fifo_cnt_q, fifo_cnt_d;

  logic [LW-1:0] len_clamped;
  logic [IW-1:0] inflight;
  logic          in_acc, rd_issue, push, pop;

  assign len_clamped = (num_words > LW'(ADDR_RANGE)) ? LW'(ADDR_RANGE) : num_words;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < MEM_LATENCY; i++) inflight = inflight + IW'(vld_pipe_q[i]);
  end

  // A read is only issued if its data is guaranteed a FIFO slot when it lands.
  assign in_ready  = (state_q == S_FILL) && (wr_cnt_q < len_q);
  assign in_acc    = in_valid && in_ready;
  assign rd_issue  = (state_q == S_DRAIN) && (rd_addr_q < len_q) &&
                     ((SW'(inflight) + SW'(fifo_cnt_q)) < SW'(SKID_DEPTH));
  assign push      = vld_pipe_q[MEM_LATENCY-1];
  assign out_valid = (fifo_cnt_q != '0);
  assign pop       = out_valid && out_ready;
  assign out_data  = out_valid ? fifo_mem_q[fifo_rp_q] : '0;

  assign busy         = (state_q == S_FILL) || (state_q == S_DRAIN);
  assign done         = (state_q == S_DONE);
  assign mem_ce0      = wr_pend_q || rd_issue;
  assign mem_we0      = wr_pend_q;
  assign mem_address0 = wr_pend_q ? wr_addr_q : rd_addr_q[ADDR_WIDTH-1:0];
  assign mem_d0       = wr_data_q;

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    wr_cnt_d  = wr_cnt_q;
    rd_addr_d = rd_addr_q;
    out_cnt_d = out_cnt_q;
    wr_pend_d = in_acc;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (in_acc) begin
      wr_addr_d = wr_cnt_q[ADDR_WIDTH-1:0];
      wr_data_d = in_data;
    end
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d     = len_clamped;
          wr_cnt_d  = '0;
          rd_addr_d = '0;
          out_cnt_d = '0;
          state_d   = (len_clamped == '0) ? S_DONE : S_FILL;
        end
      end
      S_FILL: begin
        if (in_acc) wr_cnt_d = wr_cnt_q + 1'b1;
        // wr_cnt reaching len means the final write is on the port this cycle
        if (wr_cnt_q == len_q) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (rd_issue) rd_addr_d = rd_addr_q + 1'b1;
        if (pop) begin
          out_cnt_d = out_cnt_q + 1'b1;
          if (out_cnt_q + 1'b1 == len_q) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    vld_pipe_d    = '0;
    vld_pipe_d[0] = rd_issue;
    for (int i = 1; i < MEM_LATENCY; i++) vld_pipe_d[i] = vld_pipe_q[i-1];
  end

  always_comb begin
    fifo_mem_d = fifo_mem_q;
    fifo_wp_d  = fifo_wp_q;
    fifo_rp_d  = fifo_rp_q;
    fifo_cnt_d = fifo_cnt_q;
    if (push) begin
      fifo_mem_d[fifo_wp_q] = mem_q0;
      fifo_wp_d = (fifo_wp_q == PW'(SKID_DEPTH - 1)) ? '0 : fifo_wp_q + 1'b1;
    end
    if (pop) fifo_rp_d = (fifo_rp_q == PW'(SKID_DEPTH - 1)) ? '0 : fifo_rp_q + 1'b1;
    unique case ({push, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + 1'b1;
      2'b01:   fifo_cnt_d = fifo_cnt_q - 1'b1;
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      wr_cnt_q   <= '0;
      wr_pend_q  <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      rd_addr_q  <= '0;
      out_cnt_q  <= '0;
      vld_pipe_q <= '0;
      fifo_mem_q <= '0;
      fifo_wp_q  <= '0;
      fifo_rp_q  <= '0;
      fifo_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      wr_cnt_q   <= wr_cnt_d;
      wr_pend_q  <= wr_pend_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      rd_addr_q  <= rd_addr_d;
      out_cnt_q  <= out_cnt_d;
      vld_pipe_q <= vld_pipe_d;
      fifo_mem_q <= fifo_mem_d;
      fifo_wp_q  <= fifo_wp_d;
      fifo_rp_q  <= fifo_rp_d;
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

endmodule

// File: tb/tb_krnl_partialknn_local_sp_stager.sv
// Bench for the scratchpad stager: two DUTs (read latency 1 and 3) share stimulus, and each one
// has its own scratchpad model and stream monitor.
module tb_krnl_partialknn_local_sp_stager;
  localparam int DW = 256;
  localparam int AW = 11;
  localparam int LW = AW + 1;

  typedef struct {
    logic [LW-1:0] nw;
    logic [31:0]   base;
    bit            gaps;
    bit            slow;
    int            exp_beats;
  } vec_t;

  typedef struct {
    int n_acc, n_wr, n_rd, n_out, n_done;
    int wr_bad, rd_bad, dat_bad, hold_bad;
    int max_fifo, last_wr, first_rd, first_out, done_cyc;
  } mon_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [LW-1:0] num_words = '0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          out_ready = 1'b1;
  logic          mon_clr = 1'b0;
  logic [31:0]   data_base = '0;
  int            rdy_mode = 0;
  int            cyc = 0;
  int            checks = 0;
  int            errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    #1;
    out_ready = (rdy_mode == 0) || (cyc % 3 == 0);
  end

  function automatic logic [DW-1:0] mk(input logic [31:0] b, input int k);
    logic [31:0] w;
    w = b + 32'(k);
    return {w ^ 32'h5A5A_0000, {6{w}}, w};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : inst
    localparam int LAT = (g == 0) ? 1 : 3;
    logic          in_ready, out_valid, busy, done, ce, we, any_out;
    logic [DW-1:0] out_data, d0, q0;
    logic [AW-1:0] addr;
    logic [DW-1:0] mem [0:2047];
    logic [DW-1:0] qp [LAT];
    mon_t          m;
    logic          hold_pend;
    logic [DW-1:0] hold_dat;

    krnl_partialknn_local_sp_stager #(.MEM_LATENCY(LAT)) u_dut (
      .clk(clk), .reset(rst), .start(start), .num_words(num_words),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .busy(busy), .done(done),
      .mem_address0(addr), .mem_ce0(ce), .mem_we0(we), .mem_d0(d0), .mem_q0(q0)
    );

    always @(posedge clk) begin
      if (ce && we) mem[addr] <= d0;
      qp[0] <= mem[addr];
      for (int i = 1; i < LAT; i++) qp[i] <= qp[i-1];
    end
    assign q0 = qp[LAT-1];
    assign any_out = in_ready | out_valid | busy | done | ce | we | (|out_data) | (|d0) | (|addr);

    always @(negedge clk) begin
      if (mon_clr) begin
        m <= '{default: 0, first_rd: -1, first_out: -1, done_cyc: -1, last_wr: -1};
        hold_pend <= 1'b0;
      end else begin
        if (in_valid && in_ready) m.n_acc <= m.n_acc + 1;
        if (ce && we) begin
          if (addr != AW'(m.n_wr) || d0 != mk(data_base, m.n_wr)) m.wr_bad <= m.wr_bad + 1;
          m.n_wr <= m.n_wr + 1;
          m.last_wr <= int'(addr);
        end
        if (ce && !we) begin
          if (addr != AW'(m.n_rd)) m.rd_bad <= m.rd_bad + 1;
          if (m.first_rd < 0) m.first_rd <= cyc;
          m.n_rd <= m.n_rd + 1;
        end
        if (out_valid && m.first_out < 0) m.first_out <= cyc;
        if (out_valid && hold_pend && out_data != hold_dat) m.hold_bad <= m.hold_bad + 1;
        hold_pend <= out_valid && !out_ready;
        hold_dat  <= out_data;
        if (out_valid && out_ready) begin
          if (out_data != mk(data_base, m.n_out)) m.dat_bad <= m.dat_bad + 1;
          m.n_out <= m.n_out + 1;
        end
        if (done) begin
          m.n_done <= m.n_done + 1;
          if (m.done_cyc < 0) m.done_cyc <= cyc;
        end
        if (int'(u_dut.fifo_cnt_q) > m.max_fifo) m.max_fifo <= int'(u_dut.fifo_cnt_q);
      end
    end
  end

  task automatic chk(input string nm, input int act, input int req, input bit ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  task automatic chk_eq(input string nm, input int act, input int req);
    chk(nm, act, req, act == req);
  endtask

  task automatic fill_beats(input logic [31:0] base, input int n, input bit gaps);
    int  k = 0;
    int  guard = 0;
    bit  acc;
    while (k < n && guard < 20000) begin
      in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_data  = mk(base, k);
      @(negedge clk);
      acc = in_valid && inst[0].in_ready;
      @(posedge clk); #1;
      if (acc) k++;
      guard++;
    end
    chk_eq("fill_timeout", k, n);
  endtask

  task automatic begin_burst(input logic [LW-1:0] nw, input logic [31:0] base, input bit slow,
                             output int sc);
    data_base = base;
    rdy_mode  = slow;
    mon_clr   = 1'b1;
    @(posedge clk); #1;
    mon_clr   = 1'b0;
    start     = 1'b1;
    num_words = nw;
    sc        = cyc;
    @(posedge clk); #1;
    start     = 1'b0;
  endtask

  task automatic check_mon(input string nm, input mon_t m, input int lat, input vec_t v, input int sc);
    int e = v.exp_beats;
    chk_eq({nm, "_accepted"}, m.n_acc, e);
    chk_eq({nm, "_writes"}, m.n_wr, e);
    chk_eq({nm, "_reads"}, m.n_rd, e);
    chk_eq({nm, "_outputs"}, m.n_out, e);
    chk_eq({nm, "_done_pulses"}, m.n_done, 1);
    chk_eq({nm, "_wr_addr_data_errs"}, m.wr_bad, 0);
    chk_eq({nm, "_rd_addr_errs"}, m.rd_bad, 0);
    chk_eq({nm, "_out_data_errs"}, m.dat_bad, 0);
    chk_eq({nm, "_out_hold_errs"}, m.hold_bad, 0);
    chk({nm, "_fifo_peak"}, m.max_fifo, lat + 2, m.max_fifo <= lat + 2);
    if (e > 0) begin
      chk_eq({nm, "_last_wr_addr"}, m.last_wr, e - 1);
      chk({nm, "_first_out_lat"}, m.first_out - m.first_rd, lat + 1,
          m.first_rd >= 0 && m.first_out - m.first_rd >= lat + 1);
    end else begin
      // start is sampled at edge sc+1; DONE must follow within two cycles of the start pulse
      chk({nm, "_zero_len_done_lat"}, m.done_cyc - sc, 2,
          m.done_cyc - sc >= 1 && m.done_cyc - sc <= 2);
    end
  endtask

  task automatic run_burst(input vec_t v, input string nm);
    int sc;
    int guard = 0;
    begin_burst(v.nw, v.base, v.slow, sc);
    fill_beats(v.base, v.exp_beats, v.gaps);
    // keep offering a surplus beat: it must never be taken
    in_valid = 1'b1;
    in_data  = mk(v.base, v.exp_beats);
    while (!(inst[0].m.n_done > 0 && inst[1].m.n_done > 0) && guard < 20000) begin
      @(posedge clk); #1;
      guard++;
    end
    repeat (3) @(posedge clk);
    #1 in_valid = 1'b0;
    check_mon({nm, "_lat1"}, inst[0].m, 1, v, sc);
    check_mon({nm, "_lat3"}, inst[1].m, 3, v, sc);
  endtask

  vec_t vecs[6];

  initial begin
    int sc;
    int guard;
    vecs[0] = '{nw: 12'd4,    base: 32'hA0,   gaps: 1'b0, slow: 1'b0, exp_beats: 4};
    vecs[1] = '{nw: 12'd0,    base: 32'hB0,   gaps: 1'b0, slow: 1'b0, exp_beats: 0};
    vecs[2] = '{nw: 12'd2048, base: 32'h1000, gaps: 1'b1, slow: 1'b0, exp_beats: 2048};
    vecs[3] = '{nw: 12'd7,    base: 32'h70,   gaps: 1'b1, slow: 1'b1, exp_beats: 7};
    vecs[4] = '{nw: 12'd12,   base: 32'h200,  gaps: 1'b0, slow: 1'b1, exp_beats: 12};
    vecs[5] = '{nw: 12'd3000, base: 32'h3000, gaps: 1'b0, slow: 1'b0, exp_beats: 2048};

    #3;
    chk_eq("reset_outputs_lat1", int'(inst[0].any_out), 0);
    chk_eq("reset_outputs_lat3", int'(inst[1].any_out), 0);
    @(posedge clk); #1 rst = 1'b0;

    for (int i = 0; i < 6; i++) run_burst(vecs[i], $sformatf("vec%0d", i));

    // Reset mid-DRAIN once the latency-1 DUT has delivered five beats
    begin_burst(12'd10, 32'hC0, 1'b0, sc);
    fill_beats(32'hC0, 10, 1'b0);
    in_valid = 1'b0;
    guard = 0;
    while (inst[0].m.n_out < 5 && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("midrst_reach_5_outputs", inst[0].m.n_out, 5, inst[0].m.n_out >= 5);
    chk_eq("midrst_busy_before", int'(inst[0].busy), 1);
    #2 rst = 1'b1;
    #1;
    chk_eq("midrst_outputs_lat1", int'(inst[0].any_out), 0);
    chk_eq("midrst_outputs_lat3", int'(inst[1].any_out), 0);
    @(posedge clk); #1 rst = 1'b0;
    run_burst('{nw: 12'd2, base: 32'hD0, gaps: 1'b0, slow: 1'b0, exp_beats: 2}, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
